// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus shared between the requesters and the register-file write port.
// The master side is the requester/register-file environment and the slave
// side is the arbiter.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 5,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*ID_W-1:0]   req_id;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      wb_en;
   logic [ID_W-1:0]           wb_id;
   logic [DATA_W-1:0]         wb_data;

   modport master (
      output req_valid, req_id, req_data,
      input  req_ready, wb_en, wb_id, wb_data
   );

   modport slave (
      input  req_valid, req_id, req_data,
      output req_ready, wb_en, wb_id, wb_data
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares one register-file write port between
// NUM_REQ writeback sources. The winner is registered for one cycle before it
// reaches the register file, and cycles with two or more competing sources are
// counted in a saturating conflict counter.
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 5,
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   regfile_wb_arbiter_if.slave  bus,
   output logic [CNT_W-1:0]     conflict_cnt
);
   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int POP_W  = $clog2(NUM_REQ + 1);

   // Round-robin pointer: first requester to be considered this cycle.
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;

   // Combinational arbitration result.
   logic [NUM_REQ-1:0] grant;
   logic               grant_any;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W:0]     scan_sum;
   logic [PTR_W-1:0]   scan_idx;

   // Per-requester views of the flattened id/data buses.
   logic [ID_W-1:0]    id_slice   [NUM_REQ];
   logic [DATA_W-1:0]  data_slice [NUM_REQ];
   logic [ID_W-1:0]    sel_id;
   logic [DATA_W-1:0]  sel_data;

   // Registered write towards the register file.
   logic               wb_en_q;
   logic [ID_W-1:0]    wb_id_q;
   logic [DATA_W-1:0]  wb_data_q;

   // Conflict statistics.
   logic [POP_W-1:0]   valid_cnt;
   logic               conflict;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // Requests that were pending (valid, not granted) at the last edge.
   logic [NUM_REQ-1:0] pending_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
         assign id_slice[gi]   = bus.req_id[gi*ID_W +: ID_W];
         assign data_slice[gi] = bus.req_data[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan requesters starting at rr_ptr and grant the first valid one; grants
   // depend only on valid, pointer, flush and reset, never on id or data.
   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      scan_sum  = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
            scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
         end
         scan_idx = scan_sum[PTR_W-1:0];
         if (!grant_any && bus.req_valid[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_any       = 1'b1;
            grant_idx       = scan_idx;
         end
      end
      if (flush || !reset_n) begin
         grant     = '0;
         grant_any = 1'b0;
      end
   end

   assign sel_id   = id_slice[grant_idx];
   assign sel_data = data_slice[grant_idx];

   // Advance the pointer just past the winner; hold it when nothing is granted.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_any) begin
         if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = grant_idx + PTR_W'(1);
         end
      end
   end

   // Count valid requesters and bump the saturating conflict counter.
   always_comb begin
      valid_cnt = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         valid_cnt = valid_cnt + POP_W'(bus.req_valid[k]);
      end
      conflict = !flush && (valid_cnt >= POP_W'(2));
      cnt_d    = cnt_q;
      if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // State registers: pointer, registered write (x0 writes stay disabled),
   // conflict counter and the pending-request tracker.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr_q  <= '0;
         wb_en_q   <= 1'b0;
         wb_id_q   <= '0;
         wb_data_q <= '0;
         cnt_q     <= '0;
         pending_q <= '0;
      end else begin
         rr_ptr_q  <= rr_ptr_d;
         wb_en_q   <= grant_any && (sel_id != '0);
         if (grant_any) begin
            wb_id_q   <= sel_id;
            wb_data_q <= sel_data;
         end
         cnt_q     <= cnt_d;
         pending_q <= bus.req_valid & ~grant;
      end
   end

   assign bus.req_ready = grant;
   assign bus.wb_en     = wb_en_q;
   assign bus.wb_id     = wb_id_q;
   assign bus.wb_data   = wb_data_q;
   assign conflict_cnt  = cnt_q;

   // A request left waiting must stay valid with stable id and data.
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_proto
         a_hold : assert property (@(posedge clk) disable iff (!reset_n)
            pending_q[gi] |-> (bus.req_valid[gi] && $stable(id_slice[gi]) && $stable(data_slice[gi])));
      end
   endgenerate
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_regfile_wb_arbiter;
   localparam int N  = 2;
   localparam int IW = 5;
   localparam int DW = 32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        flush;
   logic [15:0] cnt;
   logic [3:0]  cnt_s;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter_if #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW)) bus ();
   regfile_wb_arbiter_if #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW)) bus_s ();

   assign bus_s.req_valid = bus.req_valid;
   assign bus_s.req_id    = bus.req_id;
   assign bus_s.req_data  = bus.req_data;

   regfile_wb_arbiter #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus), .conflict_cnt(cnt));

   regfile_wb_arbiter #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW), .CNT_W(4)) dut_s (
      .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus_s), .conflict_cnt(cnt_s));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [IW-1:0] id, input logic [DW-1:0] d);
      bus.req_valid[i]         = v;
      bus.req_id[i*IW +: IW]   = id;
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic do_reset();
      step();
      reset_n = 1'b0;
      flush   = 1'b0;
      set_req(0, 1'b0, '0, '0);
      set_req(1, 1'b0, '0, '0);
      step();
      step();
      reset_n = 1'b1;
   endtask

   // Behavioural model and per-cycle comparison.
   initial begin : cmp
      int          m_ptr;
      logic        m_en;
      logic [IW-1:0] m_id;
      logic [DW-1:0] m_data;
      int          m_cnt;
      int          m_cnt_s;
      int          gidx;
      logic [N-1:0] v;
      logic [N-1:0] eg;
      logic        fl;
      logic [N*IW-1:0] ids;
      logic [N*DW-1:0] datas;
      m_ptr = 0; m_en = 0; m_id = '0; m_data = '0; m_cnt = 0; m_cnt_s = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_ptr = 0; m_en = 0; m_id = '0; m_data = '0; m_cnt = 0; m_cnt_s = 0;
            chk("rst_ready", 64'(bus.req_ready), 64'(0));
            chk("rst_wb_en", 64'(bus.wb_en), 64'(0));
            chk("rst_wb_id", 64'(bus.wb_id), 64'(0));
            chk("rst_wb_data", 64'(bus.wb_data), 64'(0));
            chk("rst_cnt", 64'(cnt), 64'(0));
            chk("rst_cnt_s", 64'(cnt_s), 64'(0));
         end else begin
            v = bus.req_valid; fl = flush; ids = bus.req_id; datas = bus.req_data;
            gidx = -1;
            if (!fl) begin
               for (int k = 0; k < N; k++) begin
                  if (gidx < 0 && v[(m_ptr + k) % N]) gidx = (m_ptr + k) % N;
               end
            end
            eg = '0;
            if (gidx >= 0) eg[gidx] = 1'b1;
            chk("ready", 64'(bus.req_ready), 64'(eg));
            chk("ready_s", 64'(bus_s.req_ready), 64'(eg));
            chk("wb_en", 64'(bus.wb_en), 64'(m_en));
            chk("wb_en_s", 64'(bus_s.wb_en), 64'(m_en));
            chk("wb_id", 64'(bus.wb_id), 64'(m_id));
            chk("wb_data", 64'(bus.wb_data), 64'(m_data));
            chk("cnt", 64'(cnt), 64'(m_cnt));
            chk("cnt_s", 64'(cnt_s), 64'(m_cnt_s));
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
               m_ptr = 0; m_en = 0; m_id = '0; m_data = '0; m_cnt = 0; m_cnt_s = 0;
            end else begin
               if (gidx >= 0) begin
                  m_id   = ids[gidx*IW +: IW];
                  m_data = datas[gidx*DW +: DW];
                  m_en   = (m_id != 0);
                  m_ptr  = (gidx + 1) % N;
                  $display("TXN t=%0t req=%0d id=%0d data=%08h", $time, gidx, m_id, m_data);
               end else begin
                  m_en = 1'b0;
               end
               if (!fl && $countones(v) >= 2) begin
                  if (m_cnt < 65535) m_cnt++;
                  if (m_cnt_s < 15) m_cnt_s++;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [N-1:0] g;
      reset_n = 1'b0;
      flush   = 1'b0;
      bus.req_valid = '0;
      bus.req_id    = '0;
      bus.req_data  = '0;
      step();
      @(negedge clk);
      chk("t0_ready", 64'(bus.req_ready), 64'(0));
      chk("t0_cnt", 64'(cnt), 64'(0));
      step();
      reset_n = 1'b1;

      // T1 single request
      step();
      set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_ready", 64'(bus.req_ready), 64'(2'b01));
      step();
      set_req(0, 1'b0, '0, '0);
      @(negedge clk);
      chk("t1_wb_en", 64'(bus.wb_en), 64'(1));
      chk("t1_wb_id", 64'(bus.wb_id), 64'(5));
      chk("t1_wb_data", 64'(bus.wb_data), 64'(32'hDEADBEEF));

      // T2 round robin from reset
      do_reset();
      set_req(0, 1'b1, 5'd3, 32'h0000_0033);
      set_req(1, 1'b1, 5'd4, 32'h0000_0044);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("t2_ready", 64'(bus.req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
         step();
      end
      set_req(1, 1'b0, '0, '0);
      @(negedge clk);
      chk("t2_cnt", 64'(cnt), 64'(4));
      chk("t2_ready_tail", 64'(bus.req_ready), 64'(2'b01));
      step();
      set_req(0, 1'b0, '0, '0);

      // T3 x0 request, then T4 flush
      do_reset();
      set_req(0, 1'b1, 5'd0, 32'h0000_1234);
      @(negedge clk);
      chk("t3_ready", 64'(bus.req_ready), 64'(2'b01));
      step();
      set_req(0, 1'b1, 5'd2, 32'h0000_2222);
      set_req(1, 1'b1, 5'd4, 32'h0000_4444);
      @(negedge clk);
      chk("t3_wb_en", 64'(bus.wb_en), 64'(0));
      chk("t3_wb_data", 64'(bus.wb_data), 64'(32'h1234));
      chk("t3_ptr", 64'(bus.req_ready), 64'(2'b10));
      step();
      flush = 1'b1;
      set_req(1, 1'b1, 5'd6, 32'h0000_6666);
      @(negedge clk);
      chk("t4_ready_a", 64'(bus.req_ready), 64'(2'b00));
      chk("t4_wb_en_a", 64'(bus.wb_en), 64'(1));
      chk("t4_wb_id_a", 64'(bus.wb_id), 64'(4));
      chk("t4_cnt_a", 64'(cnt), 64'(1));
      step();
      @(negedge clk);
      chk("t4_ready_b", 64'(bus.req_ready), 64'(2'b00));
      chk("t4_wb_en_b", 64'(bus.wb_en), 64'(0));
      chk("t4_cnt_b", 64'(cnt), 64'(1));
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("t4_resume", 64'(bus.req_ready), 64'(2'b01));
      step();
      set_req(0, 1'b0, '0, '0);
      @(negedge clk);
      chk("t4_ready_c", 64'(bus.req_ready), 64'(2'b10));
      chk("t4_cnt_c", 64'(cnt), 64'(2));
      chk("t4_wb_id_c", 64'(bus.wb_id), 64'(2));
      step();
      set_req(1, 1'b0, '0, '0);
      @(negedge clk);
      chk("t4_wb_data_d", 64'(bus.wb_data), 64'(32'h6666));

      // T5 reset between grant and write
      step();
      set_req(0, 1'b1, 5'd7, 32'hA5A5_0007);
      @(negedge clk);
      chk("t5_ready", 64'(bus.req_ready), 64'(2'b01));
      #2 reset_n = 1'b0;
      #1;
      chk("t5_ready_rst", 64'(bus.req_ready), 64'(0));
      chk("t5_wb_en_rst", 64'(bus.wb_en), 64'(0));
      chk("t5_wb_id_rst", 64'(bus.wb_id), 64'(0));
      chk("t5_cnt_rst", 64'(cnt), 64'(0));
      set_req(0, 1'b0, '0, '0);
      step();
      chk("t5_dropped", 64'(bus.wb_en), 64'(0));
      step();
      reset_n = 1'b1;
      set_req(0, 1'b1, 5'd3, 32'h0000_0003);
      set_req(1, 1'b1, 5'd4, 32'h0000_0004);
      @(negedge clk);
      chk("t5_ptr0", 64'(bus.req_ready), 64'(2'b01));
      step();
      set_req(0, 1'b0, '0, '0);
      @(negedge clk);
      chk("t5_ptr1", 64'(bus.req_ready), 64'(2'b10));
      step();
      set_req(1, 1'b0, '0, '0);

      // T6 saturation of the narrow counter
      do_reset();
      set_req(0, 1'b1, 5'd3, 32'h0000_0030);
      set_req(1, 1'b1, 5'd4, 32'h0000_0040);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("t6_ready", 64'(bus_s.req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
         step();
      end
      set_req(1, 1'b0, '0, '0);
      @(negedge clk);
      chk("t6_cnt_s", 64'(cnt_s), 64'(15));
      chk("t6_cnt", 64'(cnt), 64'(20));
      step();
      set_req(0, 1'b0, '0, '0);

      // Randomized traffic obeying the hold-until-granted rule
      do_reset();
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         g = bus.req_ready;
         step();
         for (int i = 0; i < N; i++) begin
            if (!(bus.req_valid[i] && !g[i])) begin
               if ($urandom_range(0, 99) < 65) begin
                  set_req(i, 1'b1,
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7)),
                          32'($urandom));
               end else begin
                  set_req(i, 1'b0, '0, '0);
               end
            end
         end
         flush = ($urandom_range(0, 9) == 0);
      end

      // Drain outstanding requests
      for (int c = 0; c < 8; c++) begin
         flush = 1'b0;
         @(negedge clk);
         g = bus.req_ready;
         step();
         for (int i = 0; i < N; i++) begin
            if (g[i]) set_req(i, 1'b0, '0, '0);
         end
      end
      chk("drain_done", 64'(bus.req_valid), 64'(0));
      step();
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
